// File: rtl/sccb_camera_config.sv
// SCCB (I2C-like) master driven by a blocking custom instruction; programs OV7670 registers.
// Optional SCCB_ACK_CHECK_EN: sample the slave ACK slot and report a sticky NACK in ciResult[8].
module sccb_camera_config #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         clockFrequencyInHz  = 50000000,
    parameter int         sccbFrequencyInHz   = 100000,
    parameter logic [6:0] slaveAddress        = 7'h21
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ciStart,
    input  logic        ciCke,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone,
    output logic        sccbClkOut,
    output logic        sccbDataDriveLow,
    input  logic        sccbDataIn
);

    localparam int DivRaw = clockFrequencyInHz / (4 * sccbFrequencyInHz);
    localparam int Div    = (DivRaw < 1) ? 1 : DivRaw;
    localparam int CntW   = $clog2(Div) + 1;
    localparam logic [CntW-1:0] Reload = CntW'(Div - 1);
    localparam logic [7:0] WrId = {slaveAddress, 1'b0};
    localparam logic [7:0] RdId = {slaveAddress, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        START,
        BYTE,
        STOP,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [3:0]      bit_q, bit_d;
    logic [1:0]      idx_q, idx_d;
    logic            seg_q, seg_d;
    logic            isRead_q, isRead_d;
    logic [7:0]      reg_q, reg_d;
    logic [7:0]      data_q, data_d;
    logic [7:0]      rd_q, rd_d;
    logic            nack_q, nack_d;

    logic       isMyCi;
    logic       tick;
    logic       rxByte;
    logic [1:0] lastIdx;
    logic [7:0] txByte;
    logic       unusedBits;

    assign isMyCi  = ciStart & ciCke & (ciN == customInstructionId);
    assign tick    = (cnt_q == '0);
    assign rxByte  = isRead_q & seg_q & (idx_q == 2'd1);
    assign lastIdx = isRead_q ? 2'd1 : 2'd2;
    assign txByte  = (idx_q == 2'd0) ? (seg_q ? RdId : WrId)
                   : (idx_q == 2'd1) ? reg_q : data_q;
    assign unusedBits = ^{ciValueA[31:2], ciValueB[31:16]};

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= Reload;
            qtr_q    <= 2'd0;
            bit_q    <= 4'd0;
            idx_q    <= 2'd0;
            seg_q    <= 1'b0;
            isRead_q <= 1'b0;
            reg_q    <= 8'd0;
            data_q   <= 8'd0;
            rd_q     <= 8'd0;
            nack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            isRead_q <= isRead_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
            rd_q     <= rd_d;
            nack_q   <= nack_d;
        end
    end

    // Next-state: tick divider, quarter/bit/byte sequencing, sampling
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        seg_d    = seg_q;
        isRead_d = isRead_q;
        reg_d    = reg_q;
        data_d   = data_q;
        rd_d     = rd_q;
        nack_d   = nack_q;

        if (state_q != IDLE) begin
            cnt_d = tick ? Reload : cnt_q - 1'b1;
            if (tick) qtr_d = qtr_q + 2'd1;
        end

        if (state_q == BYTE && tick && qtr_q == 2'd2) begin
            if (rxByte && bit_q != 4'd8) rd_d = {rd_q[6:0], sccbDataIn};
`ifdef SCCB_ACK_CHECK_EN
            if (!rxByte && bit_q == 4'd8 && sccbDataIn) nack_d = 1'b1;
`endif
        end

        unique case (state_q)
            IDLE: begin
                if (isMyCi && !ciValueA[1]) begin
                    isRead_d = ciValueA[0];
                    reg_d    = ciValueA[0] ? ciValueB[7:0] : ciValueB[15:8];
                    data_d   = ciValueB[7:0];
                    nack_d   = 1'b0;
                    cnt_d    = Reload;
                    qtr_d    = 2'd0;
                    bit_d    = 4'd0;
                    idx_d    = 2'd0;
                    seg_d    = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (tick && qtr_q == 2'd3) begin
                    bit_d   = 4'd0;
                    idx_d   = 2'd0;
                    state_d = BYTE;
                end
            end
            BYTE: begin
                if (tick && qtr_q == 2'd3) begin
                    if (bit_q == 4'd8) begin
                        bit_d = 4'd0;
                        if (idx_q == lastIdx) state_d = STOP;
                        else idx_d = idx_q + 2'd1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick && qtr_q == 2'd3) begin
                    if (isRead_q && !seg_q) begin
                        seg_d   = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                cnt_d   = Reload;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: bus levels per phase quarter, CI completion and result
    always_comb begin
        sccbClkOut       = 1'b1;
        sccbDataDriveLow = 1'b0;
        ciDone           = 1'b0;
        unique case (state_q)
            IDLE: ciDone = isMyCi & ciValueA[1];
            START: begin
                sccbClkOut       = ~qtr_q[1];
                sccbDataDriveLow = (qtr_q != 2'd0);
            end
            BYTE: begin
                sccbClkOut       = qtr_q[1];
                sccbDataDriveLow = (bit_q != 4'd8) & ~rxByte
                                 & ~txByte[~bit_q[2:0]];
            end
            STOP: begin
                sccbClkOut       = (qtr_q != 2'd0);
                sccbDataDriveLow = ~qtr_q[1];
            end
            DONE: ciDone = 1'b1;
            default: ;
        endcase
        ciResult = ciDone ? {23'd0, nack_q, rd_q} : 32'd0;
    end

endmodule

// File: tb/tb_sccb_camera_config.sv
// Bench for sccb_camera_config at D=1 with a bus-level slave answering reads with 8'hA5.
// Expected bus tokens and CI results are queued at issue time and popped as they appear.
module tb_sccb_camera_config;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ciStart = 1'b0;
    logic        ciCke = 1'b0;
    logic [7:0]  ciN = 8'd0;
    logic [31:0] ciValueA = 32'd0;
    logic [31:0] ciValueB = 32'd0;
    logic [31:0] ciResult;
    logic        ciDone;
    logic        sccbClkOut;
    logic        sccbDataDriveLow;
    logic        sccbDataIn;
    logic        slaveLow = 1'b0;

    assign sccbDataIn = ~(sccbDataDriveLow | slaveLow);

    sccb_camera_config #(
        .customInstructionId(8'd0),
        .clockFrequencyInHz(800),
        .sccbFrequencyInHz(200),
        .slaveAddress(7'h21)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ciStart(ciStart),
        .ciCke(ciCke),
        .ciN(ciN),
        .ciValueA(ciValueA),
        .ciValueB(ciValueB),
        .ciResult(ciResult),
        .ciDone(ciDone),
        .sccbClkOut(sccbClkOut),
        .sccbDataDriveLow(sccbDataDriveLow),
        .sccbDataIn(sccbDataIn)
    );

    always #5 clock = ~clock;

`ifdef SCCB_ACK_CHECK_EN
    localparam logic [31:0] NackRes = 32'h1A5;
`else
    localparam logic [31:0] NackRes = 32'h0A5;
`endif
    localparam int TokS = 256;
    localparam int TokP = 512;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] b;
        bit          nack;
        logic [31:0] res;
        int          cyc;
        int          poke;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          expTok[$];
    logic [31:0] expRes[$];
    bit          monEn = 1'b0;
    bit          nackReq = 1'b0;
    vec_t        tab[6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tok(input int t);
        int e;
        if (!monEn) return;
        if (expTok.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL bus_token actual=%0d required=none", t);
        end else begin
            e = expTok.pop_front();
            check("bus_token", t, e);
        end
    endtask

    // Slave + bus monitor, sampled on the falling clock edge
    initial begin
        logic pc, ps, c, s;
        logic [7:0] sh;
        logic [7:0] rv;
        int sbit, sbyte;
        bit rmode;
        pc = 1; ps = 1; sh = 0; rv = 8'hA5;
        sbit = 0; sbyte = 0; rmode = 0;
        forever begin
            @(negedge clock);
            c = sccbClkOut;
            s = sccbDataIn;
            if (reset) begin
                sbit = 0; sbyte = 0; rmode = 0;
                slaveLow = 1'b0; pc = 1; ps = 1;
                continue;
            end
            if (pc && c && ps && !s) begin
                tok(TokS);
                sbit = 0; sbyte = 0; rmode = 0;
            end else if (pc && c && !ps && s) begin
                tok(TokP);
            end else if (!pc && c) begin
                if (sbit < 8) begin
                    sh = {sh[6:0], s};
                    sbit++;
                    if (sbit == 8) tok(int'(sh));
                end else if (sbit == 8) begin
                    if (monEn) begin
                        if (rmode && sbyte == 1) check("master_na", s, 1'b1);
                        else check("ack_slot_released", sccbDataDriveLow, 1'b0);
                    end
                    sbit = 9;
                end
            end else if (pc && !c) begin
                if (sbit == 8) begin
                    slaveLow = !(rmode && sbyte == 1)
                             && !(nackReq && !rmode && sbyte == 1);
                end else if (sbit == 9) begin
                    slaveLow = 1'b0;
                    if (sbyte == 0 && sh == 8'h43) rmode = 1;
                    sbyte++;
                    sbit = 0;
                end
                if (rmode && sbyte == 1 && sbit < 8) slaveLow = !rv[7-sbit];
            end
            pc = c;
            ps = s;
        end
    end

    task automatic run_entry(input vec_t v);
        int got;
        logic [31:0] r;
        nackReq = v.nack;
        if (v.cmd == 2'd0) begin
            expTok.push_back(TokS); expTok.push_back(8'h42);
            expTok.push_back(int'(v.b[15:8])); expTok.push_back(int'(v.b[7:0]));
            expTok.push_back(TokP);
        end else if (v.cmd == 2'd1) begin
            expTok.push_back(TokS); expTok.push_back(8'h42);
            expTok.push_back(int'(v.b[7:0])); expTok.push_back(TokP);
            expTok.push_back(TokS); expTok.push_back(8'h43);
            expTok.push_back(8'hA5); expTok.push_back(TokP);
        end
        expRes.push_back(v.res);
        @(posedge clock); #1;
        ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd0;
        ciValueA = {30'd0, v.cmd}; ciValueB = {16'd0, v.b};
        #1;
        if (v.cmd[1]) begin
            check("status_done", ciDone, 1'b1);
            r = expRes.pop_front();
            check("status_result", ciResult, r);
            @(posedge clock); #1;
            ciStart = 1'b0;
            #1;
            check("status_done_low", ciDone, 1'b0);
            return;
        end
        got = 0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clock); #1;
            if (n == 1 || n == v.poke + 1) ciStart = 1'b0;
            if (ciDone) begin
                got = n;
                break;
            end
            if (n == v.poke) begin
                ciStart = 1'b1; ciValueA = 32'd2;
                #1;
                check("busy_ci_ignored", ciDone, 1'b0);
            end
        end
        check("done_cycle", got, v.cyc);
        if (got != 0) begin
            r = expRes.pop_front();
            check("ci_result", ciResult, r);
        end else begin
            expRes.delete();
        end
        @(posedge clock); #1;
        check("done_one_cycle", ciDone, 1'b0);
        check("tokens_left", expTok.size(), 0);
        expTok.delete();
    endtask

    initial begin
        int bad;
        vec_t w;
        tab[0] = '{2'd0, 16'h1280, 1'b0, 32'h000, 117, 0};
        tab[1] = '{2'd1, 16'h000A, 1'b0, 32'h0A5, 161, 0};
        tab[2] = '{2'd2, 16'h0000, 1'b0, 32'h0A5, 0, 0};
        tab[3] = '{2'd0, 16'h3C5A, 1'b1, NackRes, 117, 40};
        tab[4] = '{2'd2, 16'h0000, 1'b0, NackRes, 0, 0};
        tab[5] = '{2'd1, 16'h001C, 1'b0, 32'h0A5, 161, 100};

        repeat (3) @(posedge clock);
        #1;
        check("rst_clk", sccbClkOut, 1'b1);
        check("rst_drive", sccbDataDriveLow, 1'b0);
        check("rst_done", ciDone, 1'b0);
        check("rst_result", ciResult, 32'd0);
        reset = 1'b0;
        monEn = 1'b1;
        repeat (2) @(posedge clock);

        for (int i = 0; i < 6; i++) run_entry(tab[i]);

        @(posedge clock); #1;
        ciStart = 1'b1; ciCke = 1'b1; ciN = 8'h05; ciValueA = 32'd2;
        #1;
        check("wrong_id_status", ciDone, 1'b0);
        @(posedge clock); #1;
        ciValueA = 32'd0;
        @(posedge clock); #1;
        ciN = 8'd0; ciCke = 1'b0; ciValueA = 32'd2;
        #1;
        check("no_cke_status", ciDone, 1'b0);
        @(posedge clock); #1;
        ciValueA = 32'd0;
        @(posedge clock); #1;
        ciStart = 1'b0;
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clock); #1;
            if (!sccbClkOut || sccbDataDriveLow || ciDone) bad++;
        end
        check("ignored_ci_bus_idle", bad, 0);

        monEn = 1'b0;
        nackReq = 1'b0;
        @(posedge clock); #1;
        ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd0;
        ciValueA = 32'd0; ciValueB = 32'h0000_1280;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clock); #1;
            if (n == 1) ciStart = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_clk", sccbClkOut, 1'b1);
        check("abort_drive", sccbDataDriveLow, 1'b0);
        check("abort_done", ciDone, 1'b0);
        reset = 1'b0;
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clock); #1;
            if (ciDone || !sccbClkOut) bad++;
        end
        check("abort_quiet", bad, 0);
        expTok.delete();
        monEn = 1'b1;
        w = '{2'd0, 16'h1180, 1'b0, 32'h000, 117, 0};
        run_entry(w);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
